// File: rtl/dtw_pkg.sv
//==============================================================================
// Module  : dtw_pkg
// Purpose : Shared constants for the DTW multi-core scheduler.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package dtw_pkg;

    localparam logic MODE_NORMAL   = 1'b0;
    localparam logic MODE_LOAD_REF = 1'b1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_REF_START = 3'd1;
    localparam logic [2:0] S_PICK      = 3'd2;
    localparam logic [2:0] S_START     = 3'd3;
    localparam logic [2:0] S_WAIT      = 3'd4;
    localparam logic [2:0] S_STREAM    = 3'd5;

    localparam logic [0:0] C_IDLE = 1'b0;
    localparam logic [0:0] C_XFER = 1'b1;

    localparam int RES_WORDS = 3;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//==============================================================================
// Module  : rr_arbiter
// Purpose : Round-robin search from pointer+1 with wrap; pointer loaded by owner.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_i,
    input  logic             load_i,
    input  logic [IDX_W-1:0] load_idx_i,
    output logic             gnt_valid_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] cand;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (load_i) begin
            ptr_q <= load_idx_i;
        end
    end

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        cand        = '0;
        for (int i = N; i >= 1; i--) begin
            cand = IDX_W'((int'(ptr_q) + i) % N);
            if (req_i[cand]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dtw_multi_sched.sv
//==============================================================================
// Module  : dtw_multi_sched
// Purpose : Shares one host source/sink stream pair between N_CORES DTW cores.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module dtw_multi_sched
    import dtw_pkg::*;
#(
    parameter int N_CORES      = 4,
    parameter int IDX_W        = 2,
    parameter int SQG_SIZE     = 250,
    parameter int WAIT_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    op_mode,
    input  logic                    run,
    input  logic [31:0]             ref_len,
    input  logic                    src_fifo_empty,
    output logic                    src_fifo_rden,
    input  logic [31:0]             src_fifo_data,
    output logic [N_CORES-1:0]      core_rs,
    output logic                    core_op_mode,
    input  logic [N_CORES-1:0]      core_busy,
    input  logic [N_CORES-1:0]      core_load_done,
    output logic [N_CORES-1:0]      core_fifo_wren,
    input  logic [N_CORES-1:0]      core_fifo_full,
    output logic [31:0]             core_fifo_data,
    input  logic [N_CORES-1:0]      res_fifo_empty,
    output logic [N_CORES-1:0]      res_fifo_rden,
    input  logic [32*N_CORES-1:0]   res_fifo_data,
    output logic                    sink_fifo_wren,
    input  logic                    sink_fifo_full,
    output logic [31:0]             sink_fifo_data,
    output logic                    sink_fifo_last,
    output logic                    err_timeout,
    output logic [31:0]             dbg_dispatched,
    output logic [31:0]             dbg_collected
);

    localparam int              TO_W    = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(WAIT_TIMEOUT - 1);
    localparam logic [31:0]     QRY_LEN = 32'(SQG_SIZE + 1);
    localparam logic [1:0]      RES_LAST = 2'(RES_WORDS - 1);

    logic [2:0]         state_q, state_d;
    logic [N_CORES-1:0] target_q, target_d;
    logic               mode_q, mode_d;
    logic [31:0]        wcnt_q, wcnt_d;
    logic [TO_W-1:0]    wait_q, wait_d;
    logic               err_q, err_d;
    logic [31:0]        disp_q, disp_d;

    logic [0:0]         cstate_q, cstate_d;
    logic [IDX_W-1:0]   cgnt_q, cgnt_d;
    logic [1:0]         cwcnt_q, cwcnt_d;
    logic [31:0]        coll_q, coll_d;

    logic               pick_valid, pick_load;
    logic [IDX_W-1:0]   pick_idx;
    logic               col_valid, col_done;
    logic [IDX_W-1:0]   col_idx;

    logic [31:0]        len;
    logic               xfer;

    rr_arbiter #(.N(N_CORES), .IDX_W(IDX_W)) u_pick_arb (
        .clk         (clk),
        .rst         (rst),
        .req_i       (~core_busy),
        .load_i      (pick_load),
        .load_idx_i  (pick_idx),
        .gnt_valid_o (pick_valid),
        .gnt_idx_o   (pick_idx)
    );

    rr_arbiter #(.N(N_CORES), .IDX_W(IDX_W)) u_coll_arb (
        .clk         (clk),
        .rst         (rst),
        .req_i       (~res_fifo_empty),
        .load_i      (col_done),
        .load_idx_i  (cgnt_q),
        .gnt_valid_o (col_valid),
        .gnt_idx_o   (col_idx)
    );

    // Zero-latency pass-through: a word moves only when every target can take it.
    always_comb begin
        len  = (mode_q == MODE_LOAD_REF) ? ref_len : QRY_LEN;
        xfer = (state_q == S_STREAM) && (len != 32'd0) && !src_fifo_empty
               && ((core_fifo_full & target_q) == '0);
    end

    assign src_fifo_rden  = xfer;
    assign core_fifo_wren = xfer ? target_q : '0;
    assign core_fifo_data = src_fifo_data;
    assign core_op_mode   = mode_q;
    assign err_timeout    = err_q;
    assign dbg_dispatched = disp_q;
    assign dbg_collected  = coll_q;

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        mode_d    = mode_q;
        wcnt_d    = wcnt_q;
        wait_d    = wait_q;
        err_d     = err_q;
        disp_d    = disp_q;
        core_rs   = '0;
        pick_load = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run && op_mode == MODE_LOAD_REF) begin
                    mode_d   = MODE_LOAD_REF;
                    target_d = '1;
                    state_d  = S_REF_START;
                end else if (run && (&core_load_done) && !src_fifo_empty) begin
                    mode_d  = MODE_NORMAL;
                    state_d = S_PICK;
                end
            end
            S_REF_START: begin
                core_rs = '1;
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_PICK: begin
                if (pick_valid) begin
                    target_d  = N_CORES'(1) << pick_idx;
                    pick_load = 1'b1;
                    state_d   = S_START;
                end
            end
            S_START: begin
                core_rs = target_q;
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if ((core_busy & target_q) == target_q) begin
                    wcnt_d  = '0;
                    state_d = S_STREAM;
                end else if (wait_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_STREAM: begin
                if (len == 32'd0) begin
                    state_d = S_IDLE;
                end else if (xfer) begin
                    wcnt_d = wcnt_q + 32'd1;
                    if (wcnt_q == len - 32'd1) begin
                        state_d = S_IDLE;
                        if (mode_q == MODE_NORMAL) begin
                            disp_d = disp_q + 32'd1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Collector holds its grant for a whole result so words never interleave.
    always_comb begin
        cstate_d       = cstate_q;
        cgnt_d         = cgnt_q;
        cwcnt_d        = cwcnt_q;
        coll_d         = coll_q;
        col_done       = 1'b0;
        res_fifo_rden  = '0;
        sink_fifo_wren = 1'b0;
        sink_fifo_data = '0;
        sink_fifo_last = 1'b0;
        case (cstate_q)
            C_IDLE: begin
                if (col_valid) begin
                    cgnt_d   = col_idx;
                    cwcnt_d  = '0;
                    cstate_d = C_XFER;
                end
            end
            C_XFER: begin
                sink_fifo_data = res_fifo_data[32*int'(cgnt_q) +: 32];
                sink_fifo_last = (cwcnt_q == RES_LAST);
                if (!res_fifo_empty[cgnt_q] && !sink_fifo_full) begin
                    res_fifo_rden[cgnt_q] = 1'b1;
                    sink_fifo_wren        = 1'b1;
                    if (cwcnt_q == RES_LAST) begin
                        col_done = 1'b1;
                        coll_d   = coll_q + 32'd1;
                        cstate_d = C_IDLE;
                    end else begin
                        cwcnt_d = cwcnt_q + 2'd1;
                    end
                end
            end
            default: cstate_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            target_q <= '0;
            mode_q   <= MODE_NORMAL;
            wcnt_q   <= '0;
            wait_q   <= '0;
            err_q    <= 1'b0;
            disp_q   <= '0;
            cstate_q <= C_IDLE;
            cgnt_q   <= '0;
            cwcnt_q  <= '0;
            coll_q   <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            mode_q   <= mode_d;
            wcnt_q   <= wcnt_d;
            wait_q   <= wait_d;
            err_q    <= err_d;
            disp_q   <= disp_d;
            cstate_q <= cstate_d;
            cgnt_q   <= cgnt_d;
            cwcnt_q  <= cwcnt_d;
            coll_q   <= coll_d;
        end
    end

endmodule

`default_nettype wire
